// File: rtl/window_engine.sv
// ---------------------------------------------------------------------------
// window_engine
//
// Streaming analysis-window multiplier placed between the frame buffer and
// the FFT. Each accepted sample is multiplied by the window coefficient for
// its position in the frame. The product is rounded half toward +inf and
// saturated to DATA_W bits. A latched bypass mode replaces the coefficient
// with exactly 1.0, which gives a rectangular window.
//
// Pipeline:
//   stage 1 : registers the sample, the selected coefficient, sof/eof, valid
//   stage 2 : full signed multiply, round, saturate, registers the output
// A sample presented in cycle k is on the output in cycle k+2 if nothing
// stalls. Both stages hold while the output is stalled.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = !stall, combinational)
//   in_data, in_sof     sample; in_sof forces the sample to frame index 0
//   out_valid/out_ready output handshake
//   out_data            windowed sample
//   out_sof/out_eof     output sample is frame index 0 / FRAME_LEN-1
//   out_sat             output sample was clamped
//   bypass              1 selects coefficient 1.0; latched on index-0 accept
//   coef_we/addr/wdata  coefficient write port, accepted only between frames
//   coef_err            one-cycle pulse after a rejected write
// ---------------------------------------------------------------------------
module window_engine #(
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 32,
    parameter int FRAC_W    = 24,
    parameter int FRAME_LEN = 64,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic              out_sat,
    input  logic              bypass,
    input  logic              coef_we,
    input  logic [IDX_W-1:0]  coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic              coef_err
);

    // Product is held one bit wider than DATA_W+COEF_W so adding the
    // rounding constant can never wrap.
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    // 1.0 in the shared fixed-point format.
    localparam logic [COEF_W-1:0] COEF_ONE =
        {{(COEF_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    // Half an output LSB, added before the arithmetic shift.
    localparam logic signed [PROD_W:0] ROUND_HALF =
        {{(PROD_W-FRAC_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // Output range bounds, sign-extended to the product width.
    localparam logic signed [PROD_W:0] SAT_MAX =
        {{(PROD_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W:0] SAT_MIN =
        {{(PROD_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    // ---------------------------------------------------------------------
    // Coefficient memory
    // ---------------------------------------------------------------------
    logic [COEF_W-1:0] coef_mem [FRAME_LEN];

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic              byp_q,       byp_d;
    logic              s1_valid_q,  s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,   s1_data_d;
    logic [COEF_W-1:0] s1_coef_q,   s1_coef_d;
    logic              s1_sof_q,    s1_sof_d;
    logic              s1_eof_q,    s1_eof_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_sof_q,   out_sof_d;
    logic              out_eof_q,   out_eof_d;
    logic              out_sat_q,   out_sat_d;
    logic              coef_err_q,  coef_err_d;

    // ---------------------------------------------------------------------
    // Handshake, frame position and write qualification
    // ---------------------------------------------------------------------
    logic              stall;
    logic              accept;
    logic [IDX_W-1:0]  cur_idx;
    logic              cur_first;
    logic              cur_last;
    logic              byp_sel;
    logic [COEF_W-1:0] coef_rd;
    logic              wr_ok;

    // NOTE: every signal assigned in an always_comb gets a value on every
    // path (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        stall     = out_valid_q && !out_ready;
        accept    = in_valid && !stall;
        // in_sof resynchronises the frame regardless of the current index.
        cur_idx   = in_sof ? '0 : idx_q;
        cur_first = (cur_idx == '0);
        cur_last  = (cur_idx == LAST_IDX);
        // Bypass is resampled only when an index-0 sample is taken, and that
        // sample already uses the new mode.
        byp_sel   = (accept && cur_first) ? bypass : byp_q;
        // Asynchronous read: a write in this cycle lands at the edge, so a
        // sample accepted alongside it still sees the old value.
        coef_rd   = coef_mem[cur_idx];
        // Writes only between frames; an in_sof accept starts a frame now.
        wr_ok     = coef_we && (idx_q == '0) && !(accept && in_sof);
    end

    assign in_ready = !stall;

    // ---------------------------------------------------------------------
    // Stage-2 arithmetic
    // ---------------------------------------------------------------------
    logic signed [PROD_W:0] data_ext;
    logic signed [PROD_W:0] coef_ext;
    logic signed [PROD_W:0] product;
    logic signed [PROD_W:0] rounded;
    logic signed [PROD_W:0] shifted;
    logic [DATA_W-1:0]      sat_data;
    logic                   sat_flag;

    always_comb begin
        data_ext = {{(COEF_W+1){s1_data_q[DATA_W-1]}}, s1_data_q};
        coef_ext = {{(DATA_W+1){s1_coef_q[COEF_W-1]}}, s1_coef_q};
        product  = data_ext * coef_ext;
        rounded  = product + ROUND_HALF;
        shifted  = rounded >>> FRAC_W;
        sat_data = shifted[DATA_W-1:0];
        sat_flag = 1'b0;
        if (shifted > SAT_MAX) begin
            sat_data = SAT_MAX[DATA_W-1:0];
            sat_flag = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_data = SAT_MIN[DATA_W-1:0];
            sat_flag = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        idx_d       = idx_q;
        byp_d       = byp_sel;
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_coef_d   = s1_coef_q;
        s1_sof_d    = s1_sof_q;
        s1_eof_d    = s1_eof_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        out_sat_d   = out_sat_q;
        coef_err_d  = coef_we && !wr_ok;

        if (accept) begin
            idx_d = cur_last ? '0 : cur_idx + IDX_W'(1);
        end

        // Both stages advance together; on stall everything holds so the
        // output and its flags stay stable.
        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_data_d = in_data;
                s1_coef_d = byp_sel ? COEF_ONE : coef_rd;
                s1_sof_d  = cur_first;
                s1_eof_d  = cur_last;
            end

            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = sat_data;
                out_sof_d  = s1_sof_q;
                out_eof_d  = s1_eof_q;
                out_sat_d  = sat_flag;
            end
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            byp_q       <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_coef_q   <= '0;
            s1_sof_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_sat_q   <= 1'b0;
            coef_err_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            byp_q       <= byp_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_coef_q   <= s1_coef_d;
            s1_sof_q    <= s1_sof_d;
            s1_eof_q    <= s1_eof_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_sat_q   <= out_sat_d;
            coef_err_q  <= coef_err_d;
        end
    end

    // NOTE: the coefficient memory is deliberately not reset: it must keep
    // its window across a pipeline reset and can then map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            coef_mem[coef_addr] <= coef_wdata;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_sat   = out_sat_q;
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_window_engine.sv
// ---------------------------------------------------------------------------
// tb_window_engine
//
// Directed bench for window_engine with hand-computed expected values.
// Inputs are driven 1 ns after the rising edge and outputs are read there
// too, so a sample presented in cycle k is expected on the output in
// cycle k+2.
// ---------------------------------------------------------------------------
module tb_window_engine;

    localparam int DATA_W    = 32;
    localparam int COEF_W    = 32;
    localparam int FRAC_W    = 24;
    localparam int FRAME_LEN = 64;
    localparam int IDX_W     = 6;

    // Constant sample used where the coefficient must be visible: 16.0.
    localparam logic [31:0] D16 = 32'h1000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sof;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sof;
    logic              out_eof;
    logic              out_sat;
    logic              bypass;
    logic              coef_we;
    logic [IDX_W-1:0]  coef_addr;
    logic [COEF_W-1:0] coef_wdata;
    logic              coef_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] stim_data[$];
    bit          stim_sof[$];
    bit          stim_byp[$];
    logic [31:0] exp_data[$];
    bit          exp_sof[$];
    bit          exp_eof[$];
    bit          exp_sat[$];
    logic [31:0] got_data[$];
    bit          got_sof[$];
    bit          got_eof[$];
    bit          got_sat[$];

    always #5 clk = ~clk;

    window_engine #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .FRAC_W   (FRAC_W),
        .FRAME_LEN(FRAME_LEN),
        .IDX_W    (IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_sat   (out_sat),
        .bypass    (bypass),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .coef_err  (coef_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    task automatic clear_stim();
        stim_data.delete();
        stim_sof.delete();
        stim_byp.delete();
        exp_data.delete();
        exp_sof.delete();
        exp_eof.delete();
        exp_sat.delete();
    endtask

    task automatic add(input logic [31:0] d, input bit sof, input bit byp,
                       input logic [31:0] ed, input bit esof, input bit eeof, input bit esat);
        stim_data.push_back(d);
        stim_sof.push_back(sof);
        stim_byp.push_back(byp);
        exp_data.push_back(ed);
        exp_sof.push_back(esof);
        exp_eof.push_back(eeof);
        exp_sat.push_back(esat);
    endtask

    // Writes coef[i] = base + i*stride for every index, one per cycle.
    task automatic write_coefs(input string tag, input logic [31:0] base, input logic [31:0] stride);
        for (int i = 0; i < FRAME_LEN; i++) begin
            coef_we    = 1'b1;
            coef_addr  = IDX_W'(i);
            coef_wdata = base + 32'(i) * stride;
            step();
        end
        coef_we = 1'b0;
        check({tag, "_wr_err"}, coef_err, 0);
    endtask

    // Streams the stimulus queue and collects consumed outputs. Optionally
    // drops out_ready for stall_len cycles when sample stall_at is presented.
    task automatic run_stream(input string tag, input int stall_at, input int stall_len);
        int          n;
        int          sent;
        int          cyc;
        int          budget;
        int          stall_left;
        bit          stall_done;
        bit          first_stall;
        logic [31:0] held;
        n          = stim_data.size();
        sent       = 0;
        cyc        = 0;
        budget     = n + stall_len + 16;
        stall_left = 0;
        stall_done = 1'b0;
        held       = '0;
        got_data.delete();
        got_sof.delete();
        got_eof.delete();
        got_sat.delete();
        while ((sent < n || got_data.size() < n) && cyc < budget) begin
            in_valid = (sent < n);
            if (sent < n) begin
                in_data = stim_data[sent];
                in_sof  = stim_sof[sent];
                bypass  = stim_byp[sent];
            end else begin
                in_data = '0;
                in_sof  = 1'b0;
            end
            first_stall = 1'b0;
            if (!stall_done && stall_len > 0 && sent == stall_at) begin
                stall_done  = 1'b1;
                stall_left  = stall_len;
                first_stall = 1'b1;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                if (first_stall) begin
                    check({tag, "_stall_out_valid"}, out_valid, 1);
                    check({tag, "_stall_in_ready"}, in_ready, 0);
                    held = out_data;
                end else begin
                    check($sformatf("%s_hold%0d", tag, stall_len - stall_left), out_data, held);
                end
                stall_left--;
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_sof.push_back(out_sof);
                got_eof.push_back(out_eof);
                got_sat.push_back(out_sat);
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        check({tag, "_in_budget"}, cyc < budget, 1);
        check({tag, "_count"}, got_data.size(), n);
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            check($sformatf("%s_data[%0d]", tag, i), got_data[i], exp_data[i]);
            check($sformatf("%s_sof[%0d]", tag, i), got_sof[i], exp_sof[i]);
            check($sformatf("%s_eof[%0d]", tag, i), got_eof[i], exp_eof[i]);
            check($sformatf("%s_sat[%0d]", tag, i), got_sat[i], exp_sat[i]);
        end
    endtask

    // One index-0 sample with bypass off. Any coef write must be set up by
    // the caller for the same cycle; exp_err is the coef_err that follows.
    task automatic single_sample(input string tag, input logic [31:0] d, input bit sof,
                                 input logic [31:0] exp, input bit exp_err);
        in_valid  = 1'b1;
        in_data   = d;
        in_sof    = sof;
        bypass    = 1'b0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        coef_we  = 1'b0;
        check({tag, "_coef_err"}, coef_err, exp_err);
        step();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_sof"}, out_sof, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ix;
        logic [31:0] d;

        reset      = 1'b1;
        bypass     = 1'b1;
        coef_addr  = '0;
        coef_wdata = '0;
        idle();
        do_reset();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_coef_err", coef_err, 0);
        check("rst_in_ready", in_ready, 1);

        // 1. Bypass pass-through, two-cycle latency
        bypass   = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0012_3456;
        step();
        in_data = 32'hFF00_0000;
        check("byp_lat1_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        check("byp_a_valid", out_valid, 1);
        check("byp_a_data", out_data, 32'h0012_3456);
        check("byp_a_sof", out_sof, 1);
        check("byp_a_sat", out_sat, 0);
        step();
        check("byp_b_valid", out_valid, 1);
        check("byp_b_data", out_data, 32'hFF00_0000);
        check("byp_b_sof", out_sof, 0);
        check("byp_b_sat", out_sat, 0);
        step();
        check("byp_drain_valid", out_valid, 0);

        // 2. Rounding with coefficient 0.5
        do_reset();
        write_coefs("rnd", 32'h0080_0000, 32'h0);
        clear_stim();
        add(32'h0000_0003, 0, 0, 32'h0000_0002, 1, 0, 0);
        add(32'hFFFF_FFFD, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);
        add(32'h0100_0000, 0, 0, 32'h0080_0000, 0, 0, 0);
        run_stream("rnd", -1, 0);

        // 3. Saturation with coefficient 2.0
        do_reset();
        write_coefs("sat", 32'h0200_0000, 32'h0);
        clear_stim();
        add(32'h7FFF_FFFF, 0, 0, 32'h7FFF_FFFF, 1, 0, 1);
        add(32'h8000_0000, 0, 0, 32'h8000_0000, 0, 0, 1);
        add(32'h0000_0010, 0, 0, 32'h0000_0020, 0, 0, 0);
        run_stream("sat", -1, 0);

        // 4. Backpressure over a full bypass frame
        do_reset();
        clear_stim();
        for (int i = 0; i < FRAME_LEN; i++) begin
            d = 32'h1357_9BDF + 32'(i) * 32'h0421_0843;
            add(d, 0, 1, d, i == 0, i == FRAME_LEN - 1, 0);
        end
        run_stream("bp", 20, 5);

        // 5. Resync at sample 10, bypass request at sample 30.
        // coef[i] = (2i+1)/16, so a 16.0 sample gives (2i+1)<<24, which
        // never equals the bypass output 16.0.
        write_coefs("rs", 32'h0010_0000, 32'h0020_0000);
        clear_stim();
        for (int s = 0; s < 76; s++) begin
            ix = (s < 10) ? s : (s - 10) % FRAME_LEN;
            if (s >= 74) begin
                d = D16;
            end else begin
                d = 32'(2 * ix + 1) << 24;
            end
            add(D16, s == 10, s >= 30, d, ix == 0, ix == FRAME_LEN - 1, 0);
        end
        run_stream("rs", -1, 0);

        // 6. Rejected write at idx 5, then reset mid-frame.
        // The frame restarted at sample 74 in bypass; indices 2..4 now.
        clear_stim();
        for (int i = 0; i < 3; i++) begin
            add(D16, 0, 1, D16, 0, 0, 0);
        end
        run_stream("pre_wr", -1, 0);
        coef_we    = 1'b1;
        coef_addr  = '0;
        coef_wdata = 32'h0000_0000;
        step();
        coef_we = 1'b0;
        check("wr_rej_err", coef_err, 1);
        step();
        check("wr_rej_pulse_once", coef_err, 0);
        in_valid = 1'b1;
        in_data  = D16;
        bypass   = 1'b0;
        step();
        step();
        in_valid = 1'b0;
        check("inflight_valid", out_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_valid", out_valid, 0);
        clear_stim();
        add(D16, 0, 0, 32'h0100_0000, 1, 0, 0);
        add(D16, 0, 0, 32'h0300_0000, 0, 0, 0);
        run_stream("post_rst", -1, 0);

        // 7. Write timing at idx 0
        do_reset();
        coef_we    = 1'b1;
        coef_addr  = '0;
        coef_wdata = 32'h0050_0000;
        step();
        coef_we = 1'b0;
        check("wr0_err", coef_err, 0);
        // Visible next cycle; a same-cycle write to addr 0 is not seen.
        coef_we    = 1'b1;
        coef_addr  = '0;
        coef_wdata = 32'h0070_0000;
        single_sample("same_cyc", D16, 0, 32'h0500_0000, 0);
        // Write alongside an in_sof accept is rejected.
        do_reset();
        coef_we    = 1'b1;
        coef_addr  = '0;
        coef_wdata = 32'h0090_0000;
        single_sample("sof_wr", D16, 1, 32'h0700_0000, 1);
        do_reset();
        single_sample("after_sof_wr", D16, 0, 32'h0700_0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
